mem_req_arbiter: RTL and testbench

Arbitrates the shared MemController request port between instruction fetch (IF) and the load/store buffer (LSB). It latches the winning request, holds it stable on the MemController request port until completion, and returns the result to the winner as a one-cycle done pulse. It also gates stores to the I/O window while the UART buffer is full, and handles misprediction flush by discarding speculative responses. It sits between IFetch/LSB and MemController.

---
 rtl/mem_req_arbiter_if.sv | 42 ++++
 rtl/mem_req_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_req_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IFetch, LSB) and MemController.
// master = arbiter view, slave = environment (requesters + MemController) view.
interface mem_req_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;

    logic        lsb_req;
    logic        lsb_wr;
    logic [1:0]  lsb_len;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    logic        mc_req;
    logic        mc_wr;
    logic [1:0]  mc_len;
    logic [31:0] mc_addr;
    logic [31:0] mc_wdata;
    logic        mc_done;
    logic [31:0] mc_rdata;

    modport master (
        input  if_req, if_addr,
        output if_done, if_inst,
        input  lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        output lsb_done, lsb_rdata,
        output mc_req, mc_wr, mc_len, mc_addr, mc_wdata,
        input  mc_done, mc_rdata
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_inst,
        output lsb_req, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        input  lsb_done, lsb_rdata,
        input  mc_req, mc_wr, mc_len, mc_addr, mc_wdata,
        output mc_done, mc_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing the MemController request port between IFetch and the LSB,
// with I/O store gating on a full UART buffer and flush-driven discard of speculative reads.
module mem_req_arbiter (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    io_buffer_full,
    mem_req_arbiter_if.master       bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic        rr_lsb_q, rr_lsb_d;     // 1 when LSB wins the next tie
    logic        drop_q, drop_d;
    logic        gnt_lsb_q, gnt_lsb_d;
    logic        mc_req_q, mc_req_d;
    logic        mc_wr_q, mc_wr_d;
    logic [1:0]  mc_len_q, mc_len_d;
    logic [31:0] mc_addr_q, mc_addr_d;
    logic [31:0] mc_wdata_q, mc_wdata_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        lsb_done_q, lsb_done_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        if_elig, ld_elig, st_elig, lsb_elig, pick_lsb, io_store;
    logic        flush_hits;
    logic [31:0] rdata_ext;

    assign io_store = bus.lsb_addr[17:16] == 2'b11;
    assign if_elig  = bus.if_req && !flush_in;
    assign ld_elig  = bus.lsb_req && !bus.lsb_wr && !flush_in;
    // Stores are already committed, so only the UART back-pressure can hold them.
    assign st_elig  = bus.lsb_req && bus.lsb_wr && !(io_buffer_full && io_store);
    assign lsb_elig = ld_elig || st_elig;
    assign pick_lsb = lsb_elig && (!if_elig || rr_lsb_q);
    assign flush_hits = flush_in && !(gnt_lsb_q && mc_wr_q);

    always_comb begin
        case (mc_len_q)
            2'b00:   rdata_ext = {24'b0, bus.mc_rdata[7:0]};
            2'b01:   rdata_ext = {16'b0, bus.mc_rdata[15:0]};
            default: rdata_ext = bus.mc_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_lsb_d    = rr_lsb_q;
        drop_d      = drop_q;
        gnt_lsb_d   = gnt_lsb_q;
        mc_req_d    = mc_req_q;
        mc_wr_d     = mc_wr_q;
        mc_len_d    = mc_len_q;
        mc_addr_d   = mc_addr_q;
        mc_wdata_d  = mc_wdata_q;
        if_done_d   = if_done_q;
        if_inst_d   = if_inst_q;
        lsb_done_d  = lsb_done_q;
        lsb_rdata_d = lsb_rdata_q;

        if (rdy_in) begin
            if_done_d  = 1'b0;
            lsb_done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (if_elig || lsb_elig) begin
                        if (if_elig && lsb_elig) rr_lsb_d = !pick_lsb;
                        gnt_lsb_d = pick_lsb;
                        mc_req_d  = 1'b1;
                        state_d   = ST_ISSUE;
                        if (pick_lsb) begin
                            mc_wr_d    = bus.lsb_wr;
                            mc_len_d   = (bus.lsb_len == 2'b10) ? 2'b11 : bus.lsb_len;
                            mc_addr_d  = bus.lsb_addr;
                            mc_wdata_d = bus.lsb_wdata;
                        end else begin
                            mc_wr_d    = 1'b0;
                            mc_len_d   = 2'b11;
                            mc_addr_d  = bus.if_addr;
                            mc_wdata_d = 32'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A flush landing in the same cycle as mc_done still discards the result.
                    drop_d = drop_q || flush_hits;
                    if (bus.mc_done) begin
                        mc_req_d = 1'b0;
                        if (drop_q || flush_hits) begin
                            drop_d  = 1'b0;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RESP;
                            if (gnt_lsb_q) begin
                                lsb_rdata_d = rdata_ext;
                                lsb_done_d  = 1'b1;
                            end else begin
                                if_inst_d = bus.mc_rdata;
                                if_done_d = 1'b1;
                            end
                        end
                    end
                end
                ST_RESP: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            rr_lsb_q    <= 1'b0;
            drop_q      <= 1'b0;
            gnt_lsb_q   <= 1'b0;
            mc_req_q    <= 1'b0;
            mc_wr_q     <= 1'b0;
            mc_len_q    <= 2'b00;
            mc_addr_q   <= 32'b0;
            mc_wdata_q  <= 32'b0;
            if_done_q   <= 1'b0;
            if_inst_q   <= 32'b0;
            lsb_done_q  <= 1'b0;
            lsb_rdata_q <= 32'b0;
        end else begin
            state_q     <= state_d;
            rr_lsb_q    <= rr_lsb_d;
            drop_q      <= drop_d;
            gnt_lsb_q   <= gnt_lsb_d;
            mc_req_q    <= mc_req_d;
            mc_wr_q     <= mc_wr_d;
            mc_len_q    <= mc_len_d;
            mc_addr_q   <= mc_addr_d;
            mc_wdata_q  <= mc_wdata_d;
            if_done_q   <= if_done_d;
            if_inst_q   <= if_inst_d;
            lsb_done_q  <= lsb_done_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign bus.mc_req    = mc_req_q;
    assign bus.mc_wr     = mc_wr_q;
    assign bus.mc_len    = mc_len_q;
    assign bus.mc_addr   = mc_addr_q;
    assign bus.mc_wdata  = mc_wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.lsb_done  = lsb_done_q;
    assign bus.lsb_rdata = lsb_rdata_q;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: vector table of single transactions plus hand-written
// contention, I/O gating, flush, freeze and reset sequences; responses checked via a scoreboard.
module tb_mem_req_arbiter;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic rdy_in = 1'b1;
    logic flush_in = 1'b0;
    logic io_buffer_full = 1'b0;

    mem_req_arbiter_if bus();

    mem_req_arbiter dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .io_buffer_full (io_buffer_full),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_lsb;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        is_lsb;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  exp_len;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: every done pulse must match the oldest expected response.
    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (rst_in && (bus.if_done || bus.lsb_done)) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: if_done=%b lsb_done=%b, required no pulse", bus.if_done, bus.lsb_done);
            end else begin
                e = sb_q.pop_front();
                if (bus.lsb_done !== e.is_lsb || bus.if_done === bus.lsb_done) begin
                    errors++;
                    $display("FAIL done_owner: if_done=%b lsb_done=%b, required lsb_done=%b only", bus.if_done, bus.lsb_done, e.is_lsb);
                end else if (e.chk_data) begin
                    check(e.is_lsb ? "lsb_rdata" : "if_inst", e.is_lsb ? bus.lsb_rdata : bus.if_inst, e.data);
                end
                $display("resp: %s data=0x%08h", e.is_lsb ? "LSB" : "IF ", e.is_lsb ? bus.lsb_rdata : bus.if_inst);
            end
        end
    end

    task automatic wait_mc_req(input string name);
        int n = 0;
        @(negedge clk_in);
        while (bus.mc_req !== 1'b1 && n < 20) begin
            @(negedge clk_in);
            n++;
        end
        check(name, 32'(bus.mc_req), 32'd1);
    endtask

    task automatic mc_pulse(input logic [31:0] rdata);
        bus.mc_done  = 1'b1;
        bus.mc_rdata = rdata;
        @(negedge clk_in);
        bus.mc_done  = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        if (v.is_lsb) begin
            bus.lsb_req = 1'b1; bus.lsb_wr = v.wr; bus.lsb_len = v.len;
            bus.lsb_addr = v.addr; bus.lsb_wdata = v.wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = v.addr;
        end
        wait_mc_req("grant");
        check("mc_addr", bus.mc_addr, v.addr);
        check("mc_wr", 32'(bus.mc_wr), 32'(v.wr));
        check("mc_len", 32'(bus.mc_len), 32'(v.exp_len));
        if (v.wr) check("mc_wdata", bus.mc_wdata, v.wdata);
        repeat (2) @(negedge clk_in);
        check("mc_req_held", 32'(bus.mc_req), 32'd1);
        sb_q.push_back('{v.is_lsb, !v.wr, v.exp_data});
        mc_pulse(v.rdata);
        check("done_pulse", 32'(v.is_lsb ? bus.lsb_done : bus.if_done), 32'd1);
        bus.if_req = 1'b0;
        bus.lsb_req = 1'b0;
        @(negedge clk_in);
        check("done_one_cycle", 32'(bus.if_done | bus.lsb_done), 32'd0);
        $display("txn: %s wr=%b addr=0x%08h", v.is_lsb ? "LSB" : "IF ", v.wr, v.addr);
    endtask

    initial begin
        bus.if_req = 0; bus.if_addr = 0;
        bus.lsb_req = 0; bus.lsb_wr = 0; bus.lsb_len = 0; bus.lsb_addr = 0; bus.lsb_wdata = 0;
        bus.mc_done = 0; bus.mc_rdata = 0;

        //          lsb   wr    len    addr          wdata         rdata         mclen  expected
        vecs[0] = '{1'b0, 1'b0, 2'b11, 32'h00000100, 32'h0,        32'h00A00093, 2'b11, 32'h00A00093};
        vecs[1] = '{1'b1, 1'b0, 2'b00, 32'h00000200, 32'h0,        32'hFFFFFF80, 2'b00, 32'h00000080};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h00000200, 32'h0,        32'hFFFFFF80, 2'b01, 32'h0000FF80};
        vecs[3] = '{1'b1, 1'b0, 2'b11, 32'h00000200, 32'h0,        32'hFFFFFF80, 2'b11, 32'hFFFFFF80};
        vecs[4] = '{1'b1, 1'b0, 2'b10, 32'h00000204, 32'h0,        32'hFFFFFF80, 2'b11, 32'hFFFFFF80};
        vecs[5] = '{1'b1, 1'b1, 2'b11, 32'h00001000, 32'hDEADBEEF, 32'h0,        2'b11, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 2'b00, 32'h00030000, 32'h00000041, 32'h0,        2'b00, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 2'b11, 32'h00000104, 32'h0,        32'h12345678, 2'b11, 32'h12345678};

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst_mc_req", 32'(bus.mc_req), 32'd0);
        check("rst_mc_addr", bus.mc_addr, 32'd0);
        check("rst_if_done", 32'(bus.if_done), 32'd0);
        check("rst_lsb_rdata", bus.lsb_rdata, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Contention: both held continuously, grants alternate starting with IF
        bus.if_addr = 32'h100; bus.lsb_addr = 32'h200; bus.lsb_wr = 1'b0; bus.lsb_len = 2'b11;
        bus.if_req = 1'b1; bus.lsb_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_mc_req("contend_grant");
            check("contend_addr", bus.mc_addr, (g % 2 == 1) ? 32'h200 : 32'h100);
            sb_q.push_back('{(g % 2 == 1), 1'b1, 32'hA0000000 + 32'(g)});
            @(negedge clk_in);
            mc_pulse(32'hA0000000 + 32'(g));
            check("contend_done", 32'((g % 2 == 1) ? bus.lsb_done : bus.if_done), 32'd1);
            $display("txn: contention grant %0d addr=0x%08h", g, bus.mc_addr);
        end
        bus.if_req = 1'b0; bus.lsb_req = 1'b0;
        @(negedge clk_in);

        // I/O store gated while UART buffer is full; IF still served
        bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 2'b00;
        bus.lsb_addr = 32'h00030000; bus.lsb_wdata = 32'h00000055;
        io_buffer_full = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h180;
        wait_mc_req("io_if_grant");
        check("io_if_addr", bus.mc_addr, 32'h180);
        sb_q.push_back('{1'b0, 1'b1, 32'h0BADF00D});
        @(negedge clk_in);
        mc_pulse(32'h0BADF00D);
        bus.if_req = 1'b0;
        begin
            int hi = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk_in);
                if (bus.mc_req) hi++;
            end
            check("io_store_blocked", 32'(hi), 32'd0);
        end
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        check("io_store_grant", 32'(bus.mc_req), 32'd1);
        check("io_store_wr", 32'(bus.mc_wr), 32'd1);
        check("io_store_addr", bus.mc_addr, 32'h00030000);
        check("io_store_wdata", bus.mc_wdata, 32'h00000055);
        sb_q.push_back('{1'b1, 1'b0, 32'h0});
        mc_pulse(32'h0);
        bus.lsb_req = 1'b0;
        @(negedge clk_in);
        $display("txn: io-gated store");

        // Flush during IF issue: response dropped
        bus.if_req = 1'b1; bus.if_addr = 32'h400;
        wait_mc_req("flush_if_grant");
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        bus.mc_done = 1'b1; bus.mc_rdata = 32'hCAFEF00D; bus.if_req = 1'b0;
        @(negedge clk_in);
        bus.mc_done = 1'b0;
        check("flush_if_no_done", 32'(bus.if_done), 32'd0);
        check("flush_if_mc_req", 32'(bus.mc_req), 32'd0);
        @(negedge clk_in);
        check("flush_if_no_done2", 32'(bus.if_done), 32'd0);
        check("flush_if_inst_kept", bus.if_inst, 32'h0BADF00D);
        $display("txn: flushed IF");

        // Flush coincident with mc_done on a load: dropped
        bus.lsb_req = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'b11; bus.lsb_addr = 32'h208;
        wait_mc_req("flush_ld_grant");
        @(negedge clk_in);
        flush_in = 1'b1; bus.mc_done = 1'b1; bus.mc_rdata = 32'h11112222; bus.lsb_req = 1'b0;
        @(negedge clk_in);
        flush_in = 1'b0; bus.mc_done = 1'b0;
        check("flush_ld_no_done", 32'(bus.lsb_done), 32'd0);
        check("flush_ld_mc_req", 32'(bus.mc_req), 32'd0);
        @(negedge clk_in);
        check("flush_ld_no_done2", 32'(bus.lsb_done), 32'd0);
        $display("txn: flushed load");

        // Flush during a store: still completes
        bus.lsb_req = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 2'b11;
        bus.lsb_addr = 32'h1004; bus.lsb_wdata = 32'h99;
        wait_mc_req("flush_st_grant");
        flush_in = 1'b1;
        @(negedge clk_in);
        flush_in = 1'b0;
        sb_q.push_back('{1'b1, 1'b0, 32'h0});
        mc_pulse(32'h77);
        check("flush_st_done", 32'(bus.lsb_done), 32'd1);
        bus.lsb_req = 1'b0;
        @(negedge clk_in);
        $display("txn: store under flush");

        // Freeze: mc_done during rdy_in=0 is ignored
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        wait_mc_req("freeze_grant");
        rdy_in = 1'b0;
        begin
            int bad = 0;
            for (int c = 0; c < 5; c++) begin
                bus.mc_done = (c == 1); bus.mc_rdata = 32'hFFFF0000;
                @(negedge clk_in);
                if (bus.mc_req !== 1'b1 || bus.if_done !== 1'b0) bad++;
            end
            bus.mc_done = 1'b0;
            check("freeze_hold", 32'(bad), 32'd0);
        end
        rdy_in = 1'b1;
        @(negedge clk_in);
        check("freeze_no_completion", 32'(bus.mc_req), 32'd1);
        sb_q.push_back('{1'b0, 1'b1, 32'h00001111});
        mc_pulse(32'h00001111);
        check("freeze_done", 32'(bus.if_done), 32'd1);
        bus.if_req = 1'b0;
        repeat (3) @(negedge clk_in);
        check("if_inst_hold", bus.if_inst, 32'h00001111);
        $display("txn: frozen IF");

        // Asynchronous reset mid-ISSUE
        bus.if_req = 1'b1; bus.if_addr = 32'h600;
        wait_mc_req("rst_mid_grant");
        #2 rst_in = 1'b0;
        #1;
        check("rst_mid_mc_req", 32'(bus.mc_req), 32'd0);
        check("rst_mid_mc_addr", bus.mc_addr, 32'd0);
        check("rst_mid_mc_len", 32'(bus.mc_len), 32'd0);
        check("rst_mid_if_inst", bus.if_inst, 32'd0);
        check("rst_mid_lsb_rdata", bus.lsb_rdata, 32'd0);
        bus.if_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (2) @(negedge clk_in);
        check("rst_mid_idle", 32'(bus.mc_req), 32'd0);
        $display("txn: reset mid-issue");

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
